da_bitserial_mac: RTL and testbench

DA_BITSERIAL_MAC -- requirements
Module: da_bitserial_mac

---
 rtl/da_pkg.sv | 23 ++
 rtl/da_group_sum.sv | 21 ++
 rtl/da_bitserial_mac.sv | 178 +++++++++++++++++
 tb/tb_da_bitserial_mac.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared FSM state type, default widths and accumulator-width derivation
// for the bit-serial distributed-arithmetic MAC.
package da_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } da_state_e;

  localparam int unsigned DA_DEF_DATA_WIDTH_A = 8;
  localparam int unsigned DA_DEF_DATA_WIDTH_B = 8;
  localparam int unsigned DA_DEF_K            = 8;
  localparam int unsigned DA_DEF_G            = 4;

  function automatic int unsigned da_acc_width(input int unsigned wa,
                                               input int unsigned wb,
                                               input int unsigned k);
    return wa + wb + $clog2(k);
  endfunction

endpackage

// File: rtl/da_group_sum.sv
// Group adder: sums the signed weights whose address (activation) bit is set.
module da_group_sum import da_pkg::*; #(
  parameter  int unsigned G            = DA_DEF_G,
  parameter  int unsigned DATA_WIDTH_B = DA_DEF_DATA_WIDTH_B,
  localparam int unsigned SUM_WIDTH    = DATA_WIDTH_B + $clog2(G)
) (
  input  logic [G-1:0][DATA_WIDTH_B-1:0] w_i,
  input  logic [G-1:0]                   sel_i,
  output logic signed [SUM_WIDTH-1:0]    sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < G; i++) begin
      if (sel_i[i]) begin
        sum_o = sum_o + SUM_WIDTH'(signed'(w_i[i]));
      end
    end
  end

endmodule

// File: rtl/da_bitserial_mac.sv
// Bit-serial distributed-arithmetic dot product y = sum W[k]*A[k].
// Optional output clamping is enabled by defining DA_BITSERIAL_MAC_SAT_EN.
module da_bitserial_mac import da_pkg::*; #(
  parameter int unsigned DATA_WIDTH_A = DA_DEF_DATA_WIDTH_A,
  parameter int unsigned DATA_WIDTH_B = DA_DEF_DATA_WIDTH_B,
  parameter int unsigned K            = DA_DEF_K,
  parameter int unsigned G            = DA_DEF_G,
  parameter int unsigned ACC_WIDTH    = da_acc_width(DATA_WIDTH_A, DATA_WIDTH_B, K),
  parameter int unsigned OUT_WIDTH    = ACC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [K-1:0][DATA_WIDTH_B-1:0] w_data,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [K-1:0][DATA_WIDTH_A-1:0] a_data,
  output logic                           y_valid,
  input  logic                           y_ready,
  output logic signed [OUT_WIDTH-1:0]    y_data,
  output logic                           y_sat,
  output logic                           busy
);

  localparam int unsigned NGRP     = K / G;
  localparam int unsigned GSUM_W   = DATA_WIDTH_B + $clog2(G);
  localparam int unsigned P_WIDTH  = DATA_WIDTH_B + $clog2(K);
  localparam int unsigned BIT_W    = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH_A - 1);

  if (K % G != 0) begin : g_chk_k
    $error("da_bitserial_mac: K must be a multiple of G");
  end
  if (!(G == 2 || G == 4 || G == 8)) begin : g_chk_g
    $error("da_bitserial_mac: G must be 2, 4 or 8");
  end
  if (OUT_WIDTH > ACC_WIDTH || ACC_WIDTH < P_WIDTH) begin : g_chk_w
    $error("da_bitserial_mac: inconsistent OUT_WIDTH/ACC_WIDTH");
  end

  da_state_e                       state_q;
  logic [K-1:0][DATA_WIDTH_B-1:0]  w_q;
  logic [K-1:0][DATA_WIDTH_A-1:0]  a_q;
  logic [BIT_W-1:0]                bit_q;
  logic [BIT_W-1:0]                pbit_q;
  logic                            p_vld_q;
  logic signed [P_WIDTH-1:0]       p_q;
  logic signed [P_WIDTH-1:0]       p_d;
  logic signed [ACC_WIDTH-1:0]     acc_q;
  logic signed [ACC_WIDTH-1:0]     acc_d;
  logic signed [ACC_WIDTH-1:0]     term;
  logic                            y_valid_q;
  logic signed [OUT_WIDTH-1:0]     y_data_q;
  logic                            y_sat_q;
  logic signed [OUT_WIDTH-1:0]     y_narrow;
  logic                            sat_d;
  logic [K-1:0]                    a_bits;
  logic signed [GSUM_W-1:0]        gsum [NGRP];

  always_comb begin
    a_bits = '0;
    for (int unsigned k = 0; k < K; k++) begin
      a_bits[k] = a_q[k][bit_q];
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    da_group_sum #(
      .G            (G),
      .DATA_WIDTH_B (DATA_WIDTH_B)
    ) u_group_sum (
      .w_i   (w_q[g*G +: G]),
      .sel_i (a_bits[g*G +: G]),
      .sum_o (gsum[g])
    );
  end

  always_comb begin
    p_d = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      p_d = p_d + P_WIDTH'(gsum[g]);
    end
  end

  // The partial registered for the sign bit carries negative weight.
  always_comb begin
    term  = ACC_WIDTH'(p_q) << pbit_q;
    acc_d = acc_q;
    if (p_vld_q) begin
      acc_d = (pbit_q == LAST_BIT) ? acc_q - term : acc_q + term;
    end
  end

`ifdef DA_BITSERIAL_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    y_narrow = acc_d[OUT_WIDTH-1:0];
    sat_d    = 1'b0;
    if (acc_d > SAT_MAX) begin
      y_narrow = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat_d    = 1'b1;
    end else if (acc_d < SAT_MIN) begin
      y_narrow = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat_d    = 1'b1;
    end
  end
`else
  always_comb begin
    y_narrow = acc_d[OUT_WIDTH-1:0];
    sat_d    = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      a_q       <= '0;
      bit_q     <= '0;
      pbit_q    <= '0;
      p_vld_q   <= 1'b0;
      p_q       <= '0;
      acc_q     <= '0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_sat_q   <= 1'b0;
    end else begin
      p_q     <= p_d;
      pbit_q  <= bit_q;
      p_vld_q <= (state_q == ST_RUN);
      acc_q   <= acc_d;
      case (state_q)
        ST_IDLE: begin
          if (w_valid) begin
            w_q <= w_data;
          end else if (a_valid) begin
            a_q     <= a_data;
            bit_q   <= '0;
            acc_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          bit_q <= bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
            state_q <= ST_DRAIN;
          end
        end
        // Result is taken from the final accumulate so y appears with DONE.
        ST_DRAIN: begin
          y_valid_q <= 1'b1;
          y_data_q  <= y_narrow;
          y_sat_q   <= sat_d;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (y_ready) begin
            y_valid_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w_ready = (state_q == ST_IDLE);
  assign a_ready = (state_q == ST_IDLE) && !w_valid;
  assign busy    = (state_q != ST_IDLE);
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_sat   = y_sat_q;

endmodule

// File: tb/tb_da_bitserial_mac.sv
// Scoreboard bench for da_bitserial_mac (K=8, 8-bit operands, G=4) plus a
// 12-bit-output instance whose expectation follows DA_BITSERIAL_MAC_SAT_EN.
module tb_da_bitserial_mac;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic               w_valid = 1'b0, a_valid = 1'b0, y_ready = 1'b1;
  logic [7:0][7:0]    w_data  = '0;
  logic [7:0][7:0]    a_data  = '0;
  logic               w_ready, a_ready, y_valid, y_sat, busy;
  logic signed [18:0] y_data;

  logic               w_valid1 = 1'b0, a_valid1 = 1'b0, y_ready1 = 1'b1;
  logic               w_ready1, a_ready1, y_valid1, y_sat1, busy1;
  logic signed [11:0] y_data1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  da_bitserial_mac #(
    .DATA_WIDTH_A (8),
    .DATA_WIDTH_B (8),
    .K            (8),
    .G            (4)
  ) u0 (
    .clk     (clk),
    .rst     (rst),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_data  (w_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .y_sat   (y_sat),
    .busy    (busy)
  );

  da_bitserial_mac #(
    .DATA_WIDTH_A (8),
    .DATA_WIDTH_B (8),
    .K            (8),
    .G            (4),
    .OUT_WIDTH    (12)
  ) u1 (
    .clk     (clk),
    .rst     (rst),
    .w_valid (w_valid1),
    .w_ready (w_ready1),
    .w_data  (w_data),
    .a_valid (a_valid1),
    .a_ready (a_ready1),
    .a_data  (a_data),
    .y_valid (y_valid1),
    .y_ready (y_ready1),
    .y_data  (y_data1),
    .y_sat   (y_sat1),
    .busy    (busy1)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && y_valid && y_ready) begin
      if (q0.size() == 0) begin
        check("y0_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("y0_data", y_data, e.data);
        check("y0_sat", longint'(y_sat), longint'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && y_valid1 && y_ready1) begin
      if (q1.size() == 0) begin
        check("y1_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("y1_data", y_data1, e.data);
        check("y1_sat", longint'(y_sat1), longint'(e.sat));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is just after a rising edge; returns just after the load edge.
  task automatic load_w(input logic [63:0] w);
    w_data  = w;
    w_valid = 1'b1;
    @(negedge clk);
    check("w_ready_idle", longint'(w_ready), 1);
    step();
    w_valid = 1'b0;
  endtask

  // Caller is just after a rising edge; returns just after the acceptance edge.
  task automatic send_a(input logic [63:0] a, input longint e, input bit s, input bit push);
    int n;
    a_data  = a;
    a_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ready && n < 100);
    check("a_ready_wait", longint'(a_ready), 1);
    if (push) q0.push_back('{data: e, sat: s});
    step();
    a_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_y(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!y_valid && n < 200);
    check({tag, "_latency"}, longint'(cyc - t0), 9);
    if (y_ready) begin
      @(negedge clk);
      check({tag, "_done_exit"}, longint'({y_valid, busy}), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] w35;
    int          wv [8] = '{1, -2, 3, -4, 5, -6, 7, -8};
    int          n;

    @(negedge clk);
    check("rst_y_valid", longint'(y_valid), 0);
    check("rst_y_data",  y_data, 0);
    check("rst_y_sat",   longint'(y_sat), 0);
    check("rst_busy",    longint'(busy), 0);
    check("rst_w_ready", longint'(w_ready), 1);
    check("rst_a_ready", longint'(a_ready), 1);
    step();
    rst = 1'b1;
    step();

    // All ones -> 8
    load_w({8{8'd1}});
    send_a({8{8'd1}}, 8, 1'b0, 1'b1);
    wait_y("ones");

    // Most negative operands -> 131072
    step();
    load_w({8{8'h80}});
    send_a({8{8'h80}}, 131072, 1'b0, 1'b1);
    wait_y("minmin");

    // Simultaneous weight load and activation request: weights win
    step();
    for (int k = 0; k < 8; k++) w35[k*8 +: 8] = 8'(wv[k]);
    w_data  = w35;
    w_valid = 1'b1;
    a_data  = {8{8'd127}};
    a_valid = 1'b1;
    @(negedge clk);
    check("simul_a_ready", longint'(a_ready), 0);
    check("simul_w_ready", longint'(w_ready), 1);
    step();
    w_valid = 1'b0;
    check("simul_busy", longint'(busy), 0);
    send_a({8{8'd127}}, -508, 1'b0, 1'b1);
    wait_y("alt");

    // Back-pressure in DONE
    step();
    y_ready = 1'b0;
    send_a({8{8'd2}}, -8, 1'b0, 1'b1);
    wait_y("hold");
    step();
    a_data  = {8{8'd3}};
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_y_valid", longint'(y_valid), 1);
      check("hold_y_data",  y_data, -8);
      check("hold_a_ready", longint'(a_ready), 0);
      check("hold_busy",    longint'(busy), 1);
    end
    step();
    y_ready = 1'b1;
    @(negedge clk);
    check("hs_a_ready", longint'(a_ready), 0);
    step();
    send_a({8{8'd3}}, -12, 1'b0, 1'b1);
    wait_y("after_hold");

    // Reset during RUN bit 3, then compute with cleared weights
    step();
    send_a({8{8'd1}}, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_y_valid", longint'(y_valid), 0);
    check("midrst_busy",    longint'(busy), 0);
    check("midrst_w_ready", longint'(w_ready), 1);
    step();
    step();
    rst = 1'b1;
    step();
    send_a({8{8'd5}}, 0, 1'b0, 1'b1);
    wait_y("zero_w");

    // Narrow output instance
    step();
    w_data   = {8{8'd127}};
    w_valid1 = 1'b1;
    step();
    w_valid1 = 1'b0;
    a_data   = {8{8'd127}};
    a_valid1 = 1'b1;
`ifdef DA_BITSERIAL_MAC_SAT_EN
    q1.push_back('{data: 2047, sat: 1'b1});
`else
    q1.push_back('{data: -2040, sat: 1'b0});
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ready1 && n < 100);
    check("a1_ready_wait", longint'(a_ready1), 1);
    step();
    a_valid1 = 1'b0;

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("q0_drained", longint'(q0.size()), 0);
    check("q1_drained", longint'(q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
